// File: rtl/rv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rv_fetch_pkg
// Shared definitions for the RV32IC instruction fetch/align stage.
//   RESET_PC_DEF : default PC after reset
//   OPC_32BIT    : low two bits of a halfword that mark a 32-bit instruction
//   NOP          : canonical RV32I NOP (addi x0, x0, 0)
//   fetch_state_e: per-cycle fetch situation decoded from PC and buffer
// -----------------------------------------------------------------------------
package rv_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [1:0]  OPC_32BIT    = 2'b11;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef enum logic [1:0] {
        ALIGNED   = 2'd0,
        HALF_HIT  = 2'd1,
        HALF_MISS = 2'd2
    } fetch_state_e;

    // A halfword starts a 32-bit instruction when its length tag is 2'b11.
    function automatic logic is_32bit(input logic [15:0] hw);
        return (hw[1:0] == OPC_32BIT);
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// -----------------------------------------------------------------------------
// fetch_aligner
// Instruction fetch/align stage for an RV32IC core. Owns the PC, addresses a
// combinational word-wide instruction memory and splits the fetched words into
// 16-bit and 32-bit instructions (including 32-bit ones straddling a word
// boundary, using a one-halfword buffer). One instruction per cycle is handed
// to decode over a valid/ready handshake; redirects restart fetch.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   imem_addr        : word address to instruction memory (combinational)
//   imem_data        : word returned by memory in the same cycle
//   redirect_valid/pc: taken branch/jump target (bit 0 ignored)
//   out_valid/ready  : handshake towards decode
//   out_instr        : raw instruction, compressed forms zero-extended
//   out_pc, out_is_c : PC of out_instr, 1 = 16-bit instruction
// -----------------------------------------------------------------------------
module fetch_aligner
    import rv_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              out_is_c
);

    logic [31:0]       pc_r;
    logic [15:0]       buf_hw_r;
    logic [31:0]       buf_pc_r;
    logic              buf_valid_r;
    logic              out_valid_r;
    logic [31:0]       out_instr_r;
    logic [31:0]       out_pc_r;
    logic              out_is_c_r;

    fetch_state_e      state_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [ADDR_W-1:0] addr_s;
    logic              hit_s;
    logic              can_adv_s;
    logic              emit_s;
    logic [31:0]       emit_instr_s;
    logic              emit_is_c_s;
    logic [31:0]       pc_next_s;
    logic [15:0]       buf_hw_next_s;
    logic [31:0]       buf_pc_next_s;
    logic              buf_valid_next_s;
    logic [31:0]       redirect_tgt_s;

    assign word_idx_s     = pc_r[ADDR_W+1:2];
    assign hit_s          = buf_valid_r && (buf_pc_r == pc_r);
    // Nothing moves while decode is holding a presented instruction.
    assign can_adv_s      = !out_valid_r || out_ready;
    // Masking (rather than slicing) keeps all target bits in use; bit 0 is dropped.
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFE;

    // Decode the fetch situation and compute the emitted instruction and next state.
    always_comb begin
        state_s          = ALIGNED;
        addr_s           = word_idx_s;
        emit_s           = 1'b0;
        emit_instr_s     = 32'h0000_0000;
        emit_is_c_s      = 1'b0;
        pc_next_s        = pc_r;
        buf_hw_next_s    = buf_hw_r;
        buf_pc_next_s    = buf_pc_r;
        buf_valid_next_s = buf_valid_r;

        if (!pc_r[1]) begin
            state_s = ALIGNED;
        end else if (hit_s) begin
            state_s = HALF_HIT;
        end else begin
            state_s = HALF_MISS;
        end

        case (state_s)
            ALIGNED: begin
                emit_s = 1'b1;
                if (!is_32bit(imem_data[15:0])) begin
                    // Keep the upper halfword; it is the next instruction start.
                    emit_instr_s     = {16'h0000, imem_data[15:0]};
                    emit_is_c_s      = 1'b1;
                    pc_next_s        = pc_r + 32'd2;
                    buf_hw_next_s    = imem_data[31:16];
                    buf_pc_next_s    = pc_r + 32'd2;
                    buf_valid_next_s = 1'b1;
                end else begin
                    emit_instr_s     = imem_data;
                    emit_is_c_s      = 1'b0;
                    pc_next_s        = pc_r + 32'd4;
                    buf_valid_next_s = 1'b0;
                end
            end
            HALF_HIT: begin
                emit_s = 1'b1;
                if (!is_32bit(buf_hw_r)) begin
                    emit_instr_s     = {16'h0000, buf_hw_r};
                    emit_is_c_s      = 1'b1;
                    pc_next_s        = pc_r + 32'd2;
                    buf_valid_next_s = 1'b0;
                end else begin
                    // Straddle: upper half lives in the next word (index wraps).
                    addr_s           = word_idx_s + ADDR_W'(1'b1);
                    emit_instr_s     = {imem_data[15:0], buf_hw_r};
                    emit_is_c_s      = 1'b0;
                    pc_next_s        = pc_r + 32'd4;
                    buf_hw_next_s    = imem_data[31:16];
                    buf_pc_next_s    = pc_r + 32'd4;
                    buf_valid_next_s = 1'b1;
                end
            end
            HALF_MISS: begin
                // Odd-halfword PC with nothing buffered: one bubble to fill it.
                buf_hw_next_s    = imem_data[31:16];
                buf_pc_next_s    = pc_r;
                buf_valid_next_s = 1'b1;
            end
            default: begin
                emit_s = 1'b0;
            end
        endcase
    end

    // PC, halfword buffer and output register; reset > redirect > stall > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            buf_valid_r <= 1'b0;
            buf_hw_r    <= 16'h0000;
            buf_pc_r    <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_pc_r    <= 32'h0000_0000;
            out_is_c_r  <= 1'b0;
        end else if (redirect_valid) begin
            pc_r        <= redirect_tgt_s;
            buf_valid_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (can_adv_s) begin
            pc_r        <= pc_next_s;
            buf_hw_r    <= buf_hw_next_s;
            buf_pc_r    <= buf_pc_next_s;
            buf_valid_r <= buf_valid_next_s;
            if (emit_s) begin
                out_valid_r <= 1'b1;
                out_instr_r <= emit_instr_s;
                out_pc_r    <= pc_r;
                out_is_c_r  <= emit_is_c_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign imem_addr = addr_s;
    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_pc    = out_pc_r;
    assign out_is_c  = out_is_c_r;

endmodule

// File: tb/tb_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_fetch_aligner
// Scoreboard bench: the stimulus side keeps a halfword-level reference model of
// the instruction stream and pushes expected instructions into a queue; the
// monitor pops and compares on every accepted handshake and also checks reset
// values, redirect flushes and stall stability.
// -----------------------------------------------------------------------------
module tb_fetch_aligner;
    import rv_fetch_pkg::*;

    localparam int ADDR_W = 6;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              out_is_c;

    logic [31:0] mem [64];
    exp_t        q[$];
    logic [31:0] model_pc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_aligner #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_is_c       (out_is_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Halfword at byte address a; memory is 64 words and wraps.
    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[ADDR_W+1:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic push_expected();
        logic [15:0] h;
        exp_t e;
        h    = hw_at(model_pc);
        e.pc = model_pc;
        if (h[1:0] == 2'b11) begin
            e.instr  = {hw_at(model_pc + 32'd2), h};
            e.c      = 1'b0;
            model_pc = model_pc + 32'd4;
        end else begin
            e.instr  = {16'h0000, h};
            e.c      = 1'b1;
            model_pc = model_pc + 32'd2;
        end
        q.push_back(e);
    endtask

    task automatic top_up();
        while (q.size() < 8) push_expected();
    endtask

    task automatic restart(input logic [31:0] pc);
        q.delete();
        model_pc = pc;
        top_up();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        top_up();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        rst = 1'b0;
        restart(32'h0000_0000);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 64; i++) mem[i] = NOP;
    endtask

    // ---------------- monitor ----------------
    logic              prev_rst   = 1'b0;
    logic              prev_redir = 1'b0;
    logic              prev_stall = 1'b0;
    logic [31:0]       sv_pc, sv_instr;
    logic              sv_c;
    logic [ADDR_W-1:0] sv_addr;
    int                idle = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (prev_rst) begin
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_out_instr", out_instr, 32'd0);
            check("rst_out_pc", out_pc, 32'd0);
            check("rst_out_is_c", {31'b0, out_is_c}, 32'd0);
        end else if (prev_redir) begin
            check("redirect_flush", {31'b0, out_valid}, 32'd0);
        end else if (prev_stall) begin
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_pc", out_pc, sv_pc);
            check("stall_instr", out_instr, sv_instr);
            check("stall_is_c", {31'b0, out_is_c}, {31'b0, sv_c});
            check("stall_addr", {26'b0, imem_addr}, {26'b0, sv_addr});
        end

        if (!rst && !redirect_valid && out_valid && out_ready) begin
            idle = 0;
            n_acc++;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: got pc %h expected no instruction", out_pc);
            end else begin
                e = q.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_instr", out_instr, e.instr);
                check("sb_is_c", {31'b0, out_is_c}, {31'b0, e.c});
            end
        end else if (!rst && !redirect_valid && out_ready && !out_valid) begin
            idle++;
            if (idle > 3) begin
                n_cmp++;
                n_err++;
                $display("FAIL starvation: got %0d idle cycles expected at most 3", idle);
                idle = 0;
            end
        end else begin
            idle = 0;
        end

        prev_rst   = rst;
        prev_redir = !rst && redirect_valid;
        prev_stall = !rst && !redirect_valid && out_valid && !out_ready;
        sv_pc      = out_pc;
        sv_instr   = out_instr;
        sv_c       = out_is_c;
        sv_addr    = imem_addr;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held_pc;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        out_ready      = 1'b1;
        model_pc       = 32'h0000_0000;
        fill_nop();
        tick();

        // All 32-bit instructions, first valid after the first edge with rst low.
        fill_nop();
        mem[0] = 32'h0000_2083;
        mem[1] = 32'h0040_2103;
        mem[2] = 32'h0080_2183;
        do_reset();
        @(negedge clk);
        check("t1_latency", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t1_valid", {31'b0, out_valid}, 32'd1);
            check("t1_pc", out_pc, 32'(4 * i));
            check("t1_is_c", {31'b0, out_is_c}, 32'd0);
        end

        // Two compressed in one word, then 32-bit; no bubble.
        fill_nop();
        mem[0] = 32'h4505_0085;
        tick();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t2_valid", {31'b0, out_valid}, 32'd1);
            check("t2_pc", out_pc, 32'(2 * i));
        end

        // Straddling 32-bit instruction followed by buffered compressed one.
        fill_nop();
        mem[0] = 32'h2083_0085;
        mem[1] = 32'h4505_0000;
        tick();
        do_reset();
        tick();
        @(negedge clk);
        check("t3_pc0", out_pc, 32'h0);
        check("t3_straddle_addr", {26'b0, imem_addr}, 32'd1);
        tick();
        @(negedge clk);
        check("t3_pc2", out_pc, 32'h2);
        check("t3_instr2", out_instr, 32'h0000_2083);
        check("t3_is_c2", {31'b0, out_is_c}, 32'd0);
        tick();
        @(negedge clk);
        check("t3_valid6", {31'b0, out_valid}, 32'd1);
        check("t3_pc6", out_pc, 32'h6);
        check("t3_instr6", out_instr, 32'h0000_4505);

        // Redirect to an odd halfword while an instruction is held.
        fill_nop();
        mem[1] = 32'h0085_4505;
        tick();
        do_reset();
        tick();
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0007;
        out_ready      = 1'b1;
        restart(32'h0000_0006);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_bubble1", {31'b0, out_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("t4_bubble2", {31'b0, out_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("t4_valid", {31'b0, out_valid}, 32'd1);
        check("t4_pc", out_pc, 32'h6);
        check("t4_instr", out_instr, 32'h0000_0085);

        // Backpressure on a random program.
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        tick();
        do_reset();
        repeat (4) tick();
        out_ready = 1'b0;
        @(negedge clk);
        held_pc = out_pc;
        repeat (3) tick();
        @(negedge clk);
        check("t5_held_pc", out_pc, held_pc);
        out_ready = 1'b1;
        repeat (6) tick();

        // Reset during a straddle (also with a redirect pending: reset wins).
        fill_nop();
        mem[0] = 32'h2083_0085;
        mem[1] = 32'h4505_0000;
        tick();
        do_reset();
        tick();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        restart(32'h0000_0000);
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t6_restart_pc", out_pc, 32'h0);
        check("t6_restart_valid", {31'b0, out_valid}, 32'd1);

        // Redirect while stalled.
        tick();
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        restart(32'h0000_0010);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        @(negedge clk);
        check("t7_redirect_pc", out_pc, 32'h10);

        // Randomized traffic: stalls, redirects (incl. odd bit 0), occasional reset.
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        tick();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                restart(redirect_pc & 32'hFFFF_FFFE);
            end else begin
                redirect_valid = 1'b0;
            end
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                restart(32'h0000_0000);
            end
            tick();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (10) tick();
        check("throughput", {31'b0, (n_acc > 1000)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
Instruction fetch/align stage between the 64-word combinational instruction memory and the decoder of the RV32IC core. Owns the PC and drives the memory word address. Splits fetched words into 16-bit (compressed) and 32-bit instructions, including 32-bit instructions that straddle a word boundary. Presents one instruction per cycle to decode over a valid/ready handshake and accepts branch/jump redirects.

Parameters:
ADDR_W, 6, word-address width of instruction memory (64 words)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_addr  out  ADDR_W  word address to instruction memory (combinational from state)
imem_data  in  32  word read from instruction memory, same-cycle combinational
redirect_valid  in  1  taken branch/jump; has priority over everything except rst
redirect_pc  in  32  redirect target; bit 0 ignored (forced 0)
out_valid  out  1  instruction on out_* is valid
out_ready  in  1  decode accepts when out_valid && out_ready
out_instr  out  32  raw instruction; compressed forms zero-extended in [15:0]
out_pc  out  32  PC of out_instr
out_is_c  out  1  1 = 16-bit instruction

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, buf_valid<=0, buf_hw<=0, buf_pc<=0, out_valid<=0, out_instr<=0, out_pc<=0, out_is_c<=0.
- Halfword buffer: buf_hw (16b), buf_pc (32b), buf_valid. Hit = buf_valid && buf_pc==pc.
- Length rule: halfword[1:0]==2'b11 -> 32-bit, else compressed.
- Fetch states, decoded each cycle from pc and buffer:
  ALIGNED (pc[1]=0): imem_addr=pc[ADDR_W+1:2]. If imem_data[1:0]!=2'b11: emit {16'h0,imem_data[15:0]}, is_c=1, pc+=2, buf<=imem_data[31:16], buf_pc<=pc+2, buf_valid<=1. Else emit imem_data, is_c=0, pc+=4, buf_valid<=0.
  HALF_HIT (pc[1]=1, hit): if buf_hw compressed: emit {16'h0,buf_hw}, pc+=2, buf_valid<=0; imem_addr don't-care (drive pc[ADDR_W+1:2]). Else imem_addr=pc[ADDR_W+1:2]+1 (mod 2^ADDR_W); emit {imem_data[15:0],buf_hw}, is_c=0, pc+=4, buf<=imem_data[31:16], buf_pc<=pc+4, buf_valid<=1.
  HALF_MISS (pc[1]=1, no hit): imem_addr=pc[ADDR_W+1:2]; buf<=imem_data[31:16], buf_pc<=pc, buf_valid<=1; no emit, pc unchanged. Costs exactly one bubble; next cycle is HALF_HIT.
- Output register: loads (out_valid<=1 with emitted instr/pc/is_c) only when an instruction is emitted and (!out_valid || out_ready). When out_valid && !out_ready: out_*, pc, buffer all hold; imem_addr stable. If out_ready && nothing emitted (HALF_MISS): out_valid<=0.
- Redirect (redirect_valid=1, rst=0): pc<={redirect_pc[31:1],1'b0}, buf_valid<=0, out_valid<=0; current out_* is discarded even if out_ready=1 that cycle (decode must not consume it). Ignores stall. First instruction appears 2 edges after the redirect edge (aligned/compressed-at-aligned target), 3 edges for odd-halfword target.
- Latency from reset release: first out_valid=1 after the first edge with rst=0.
- Wrap: pc arithmetic is mod 2^32; memory word index wraps mod 2^ADDR_W (word 63 +1 -> word 0).
- Simultaneous: rst > redirect_valid > stall > normal advance.
- No decompression, no illegal-instruction detection here (downstream).

Decomposition:
- Shared package rv_fetch_pkg: RESET_PC default, OPC_32BIT=2'b11 length tag, NOP=32'h0000_0013, fetch-state enum {ALIGNED, HALF_HIT, HALF_MISS}.
- Single module; fetch-state decode and output register inline. No sub-module required.

Test Plan:
- All 32-bit: mem[0]=32'h0000_2083, mem[1]=32'h0040_2103, mem[2]=32'h0080_2183, out_ready=1 -> out_pc 0,4,8, is_c=0, out_instr matches words, out_valid from first edge after rst.
- Two compressed in one word: mem[0]=32'h4505_0085 -> (pc0, 32'h0000_0085, c=1), (pc2, 32'h0000_4505, c=1), then pc4; no bubble.
- Straddle: mem[0]=32'h2083_0085, mem[1]=32'h4505_0000 -> pc0 0x0085 c; pc2 32'h0000_2083 c=0 (imem_addr=1 that cycle); pc6 0x4505 c=1 from buffer, no bubble.
- Redirect to 32'h6 (odd halfword, empty buffer) mid-stream: out_valid=0 for 2 edges after redirect edge, then out_pc=6; prior held instruction never consumed.
- Backpressure: hold out_ready=0 3 cycles with out_valid=1 -> out_*, imem_addr, pc stable; on out_ready=1 sequence resumes with no skipped/duplicated pc.
- Reset mid-straddle (rst during HALF_HIT) and redirect while stalled -> all outputs at reset values / out_valid=0 next edge; restart at RESET_PC / target.
